bf_prog_mem: RTL and testbench

- Loadable, parametrised program store for the brainfuck CPU.
- Accepts an ASCII program byte stream over a valid/ready handshake and decodes each command character to the 3-bit opcode.
- Packs decoded opcodes into sequential addresses and records the program length.
- Serves the CPU fetch unit through a registered read port with an overrun flag.

---
 rtl/bf_pkg.sv | 46 ++++
 rtl/bf_prog_mem_if.sv | 32 +++
 rtl/bf_op_ram.sv | 30 +++
 rtl/bf_prog_mem.sv | 140 ++++++++++++++
 tb/tb_bf_prog_mem.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared types for the brainfuck program store: opcode encoding, load-state
// enum and the ASCII command decoder used while a program is streamed in.
package bf_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_INC  = 3'b111;  // '+'
  localparam op_t OP_DEC  = 3'b110;  // '-'
  localparam op_t OP_MOVR = 3'b101;  // '>'
  localparam op_t OP_MOVL = 3'b100;  // '<'
  localparam op_t OP_IF   = 3'b011;  // '['
  localparam op_t OP_BACK = 3'b010;  // ']'
  localparam op_t OP_OUT  = 3'b001;  // '.'
  localparam op_t OP_NOP  = 3'b000;  // ','

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY
  } state_t;

  typedef struct packed {
    logic valid;
    op_t  op;
  } dec_t;

  // Map one ASCII character to its opcode; valid is low for non-command bytes.
  function automatic dec_t ascii_to_op(input logic [7:0] ch);
    dec_t d;
    d.valid = 1'b1;
    d.op    = OP_NOP;
    case (ch)
      8'h2B:   d.op = OP_INC;
      8'h2D:   d.op = OP_DEC;
      8'h3E:   d.op = OP_MOVR;
      8'h3C:   d.op = OP_MOVL;
      8'h5B:   d.op = OP_IF;
      8'h5D:   d.op = OP_BACK;
      8'h2E:   d.op = OP_OUT;
      8'h2C:   d.op = OP_NOP;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bf_prog_mem_if.sv
// Bus bundle for bf_prog_mem: byte-stream load port, fetch read port and
// status. The master drives the load stream and fetch address; the slave is
// the program store.
interface bf_prog_mem_if
  import bf_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic              load_start;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] rd_addr;
  op_t               code;
  logic              rom_overrun;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              load_err;
  logic              bracket_err;

  modport master (
    output load_start, byte_data, byte_valid, rd_addr,
    input  byte_ready, code, rom_overrun, prog_len, busy, load_err, bracket_err
  );

  modport slave (
    input  load_start, byte_data, byte_valid, rd_addr,
    output byte_ready, code, rom_overrun, prog_len, busy, load_err, bracket_err
  );

endinterface

// File: rtl/bf_op_ram.sv
// Opcode array for the program store: one write port, one registered read
// port, 2**ADDR_W entries of 3 bits.
module bf_op_ram
  import bf_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  op_t               wdata,
  input  logic [ADDR_W-1:0] raddr,
  output op_t               rdata
);

  op_t mem [2**ADDR_W];
  op_t rdata_q;

  // Write the decoded opcode and register the fetch read.
  // NOTE: the array has no reset so it maps onto plain RAM; stale contents are
  // masked by the read-hit flag in the parent. Non-blocking assignments keep
  // the read returning the pre-write value in a same-address cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bf_prog_mem.sv
// bf_prog_mem: loadable program store for the brainfuck CPU. Streams ASCII
// commands in over a valid/ready handshake, packs decoded opcodes from
// address 0 and serves the fetch unit through a registered read port.
// Optional bracket-balance tracking: define BF_PROG_MEM_BRACKET_CHECK_EN.
module bf_prog_mem
  import bf_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] TERM_CHAR  = 8'h21,
  parameter op_t        DEFAULT_OP = OP_INC
) (
  input logic          clk,
  input logic          rst_n,
  bf_prog_mem_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] prog_len_q, prog_len_d;
  logic            load_err_q, load_err_d;
  logic            hit_q, hit_d;

  dec_t dec;
  logic xfer, we, term_acc, ovf;
  op_t  rdata;

  assign dec  = ascii_to_op(bus.byte_data);
  assign xfer = bus.byte_valid && (state_q == ST_LOAD);

  // Load sequencing: restart, store commands, terminate or overflow.
  // NOTE: every output of this block gets a default first so no latches form.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    load_err_d = load_err_q;
    we         = 1'b0;
    term_acc   = 1'b0;
    ovf        = 1'b0;
    // The read hit uses the current state, so nothing being loaded is visible.
    hit_d      = (state_q == ST_READY) && ({1'b0, bus.rd_addr} < prog_len_q);
    if (bus.load_start) begin
      // load_start wins over any byte offered in the same cycle.
      state_d    = ST_LOAD;
      wptr_d     = '0;
      prog_len_d = '0;
      load_err_d = 1'b0;
    end else if (xfer) begin
      if (bus.byte_data == TERM_CHAR) begin
        term_acc   = 1'b1;
        prog_len_d = wptr_q;
        state_d    = ST_READY;
      end else if (dec.valid) begin
        if (wptr_q == FULL_CNT) begin
          ovf        = 1'b1;
          load_err_d = 1'b1;
          prog_len_d = FULL_CNT;
          state_d    = ST_READY;
        end else begin
          we     = 1'b1;
          wptr_d = wptr_q + ONE;
        end
      end
    end
  end

  // Control and read-hit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wptr_q     <= '0;
      prog_len_q <= '0;
      load_err_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
      load_err_q <= load_err_d;
      hit_q      <= hit_d;
    end
  end

  bf_op_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (dec.op),
    .raddr (bus.rd_addr),
    .rdata (rdata)
  );

`ifdef BF_PROG_MEM_BRACKET_CHECK_EN
  logic [ADDR_W:0] depth_q, depth_d;
  logic            bracket_err_q, bracket_err_d;

  // Nesting depth of stored brackets; flags underflow and open brackets at end.
  always_comb begin
    depth_d       = depth_q;
    bracket_err_d = bracket_err_q;
    if (bus.load_start) begin
      depth_d       = '0;
      bracket_err_d = 1'b0;
    end else if (we && dec.op == OP_IF) begin
      depth_d = depth_q + ONE;
    end else if (we && dec.op == OP_BACK) begin
      if (depth_q == '0) bracket_err_d = 1'b1;
      else               depth_d       = depth_q - ONE;
    end else if ((term_acc || ovf) && depth_q != '0) begin
      bracket_err_d = 1'b1;
    end
  end

  // Bracket tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q       <= '0;
      bracket_err_q <= 1'b0;
    end else begin
      depth_q       <= depth_d;
      bracket_err_q <= bracket_err_d;
    end
  end

  assign bus.bracket_err = bracket_err_q;
`else
  assign bus.bracket_err = 1'b0;
`endif

  assign bus.byte_ready  = (state_q == ST_LOAD);
  assign bus.busy        = (state_q == ST_LOAD);
  assign bus.code        = hit_q ? rdata : DEFAULT_OP;
  assign bus.rom_overrun = ~hit_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_bf_prog_mem.sv
// Bench for bf_prog_mem: two instances (ADDR_W = 8 and ADDR_W = 2) share one
// stimulus stream; each is compared every cycle against a behavioural model
// of the program store kept here.
module tb_bf_prog_mem;

  localparam logic [7:0] TERM = 8'h21;
  localparam int M_EMPTY = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;
`ifdef BF_PROG_MEM_BRACKET_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk;
  logic rst_n;

  bf_prog_mem_if #(.ADDR_W(8)) bus8 ();
  bf_prog_mem_if #(.ADDR_W(2)) bus2 ();

  bf_prog_mem #(.ADDR_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bf_prog_mem #(.ADDR_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int tog_k  = 0;

  // Model state, one slot per instance (0: depth 256, 1: depth 4).
  int         m_st   [2];
  int         m_cnt  [2];
  int         m_len  [2];
  int         m_dep  [2];
  bit         m_lerr [2];
  bit         m_berr [2];
  logic [2:0] m_mem  [2][256];
  int         e_code [2];
  int         e_ovr  [2];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Opcode is the position of the character in this list.
  function automatic int op_of(input logic [7:0] b);
    string cmds = ",.][<>-+";
    for (int k = 0; k < 8; k++) if (cmds[k] == b) return k;
    return -1;
  endfunction

  task automatic model_reset(input int i);
    m_st[i] = M_EMPTY; m_cnt[i] = 0; m_len[i] = 0; m_dep[i] = 0;
    m_lerr[i] = 1'b0; m_berr[i] = 1'b0; e_code[i] = 7; e_ovr[i] = 1;
  endtask

  task automatic model_step(input int i, input bit ls, input logic [7:0] b,
                            input bit v, input int r);
    int depth = (i == 0) ? 256 : 4;
    int op;
    bit hit = (m_st[i] == M_READY) && (r < m_len[i]);
    e_code[i] = hit ? int'(m_mem[i][r]) : 7;
    e_ovr[i]  = hit ? 0 : 1;
    if (ls) begin
      m_st[i] = M_LOAD; m_cnt[i] = 0; m_len[i] = 0; m_dep[i] = 0;
      m_lerr[i] = 1'b0; m_berr[i] = 1'b0;
    end else if (m_st[i] == M_LOAD && v) begin
      op = op_of(b);
      if (b == TERM) begin
        m_len[i] = m_cnt[i];
        if (BCHK && m_dep[i] != 0) m_berr[i] = 1'b1;
        m_st[i] = M_READY;
      end else if (op >= 0) begin
        if (m_cnt[i] == depth) begin
          m_lerr[i] = 1'b1;
          m_len[i]  = depth;
          if (BCHK && m_dep[i] != 0) m_berr[i] = 1'b1;
          m_st[i] = M_READY;
        end else begin
          m_mem[i][m_cnt[i]] = 3'(op);
          m_cnt[i]++;
          if (op == 3) m_dep[i]++;
          else if (op == 2) begin
            if (m_dep[i] == 0) begin
              if (BCHK) m_berr[i] = 1'b1;
            end else m_dep[i]--;
          end
        end
      end
    end
  endtask

  task automatic check_dut(input int i);
    if (i == 0) begin
      check("w8.code",        int'(bus8.code),        e_code[0]);
      check("w8.rom_overrun", int'(bus8.rom_overrun), e_ovr[0]);
      check("w8.prog_len",    int'(bus8.prog_len),    m_len[0]);
      check("w8.byte_ready",  int'(bus8.byte_ready),  int'(m_st[0] == M_LOAD));
      check("w8.busy",        int'(bus8.busy),        int'(m_st[0] == M_LOAD));
      check("w8.load_err",    int'(bus8.load_err),    int'(m_lerr[0]));
      check("w8.bracket_err", int'(bus8.bracket_err), int'(m_berr[0]));
    end else begin
      check("w2.code",        int'(bus2.code),        e_code[1]);
      check("w2.rom_overrun", int'(bus2.rom_overrun), e_ovr[1]);
      check("w2.prog_len",    int'(bus2.prog_len),    m_len[1]);
      check("w2.byte_ready",  int'(bus2.byte_ready),  int'(m_st[1] == M_LOAD));
      check("w2.busy",        int'(bus2.busy),        int'(m_st[1] == M_LOAD));
      check("w2.load_err",    int'(bus2.load_err),    int'(m_lerr[1]));
      check("w2.bracket_err", int'(bus2.bracket_err), int'(m_berr[1]));
    end
  endtask

  // Apply one cycle of inputs to both instances and check after the edge.
  task automatic cycle(input bit ls, input logic [7:0] b, input bit v, input int r);
    bus8.load_start = ls; bus8.byte_data = b; bus8.byte_valid = v; bus8.rd_addr = 8'(r);
    bus2.load_start = ls; bus2.byte_data = b; bus2.byte_valid = v; bus2.rd_addr = 2'(r);
    model_step(0, ls, b, v, r & 255);
    model_step(1, ls, b, v, r & 3);
    @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // mode 0: valid held high; 1: valid every other cycle; 2: random valid.
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit done = 1'b0;
    int tries = 0;
    while (!done) begin
      bit v;
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = tog_k[0];
      else                v = ($urandom_range(0, 2) != 0) || (tries > 20);
      tog_k++;
      tries++;
      done = v || (m_st[0] != M_LOAD);
      cycle(1'b0, b, v, $urandom_range(0, 300));
    end
  endtask

  task automatic send(input string s, input int mode);
    for (int c = 0; c < s.len(); c++) send_byte(s[c], mode);
  endtask

  task automatic read_addrs(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) cycle(1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic read_phase(input int n);
    for (int k = 0; k < n; k++)
      cycle(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            $urandom_range(0, m_len[0] + 3));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #2;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    string pool = "+-<>[].,ab \n";
    bus8.load_start = 1'b0; bus8.byte_data = 8'h00; bus8.byte_valid = 1'b0; bus8.rd_addr = '0;
    bus2.load_start = 1'b0; bus2.byte_data = 8'h00; bus2.byte_valid = 1'b0; bus2.rd_addr = '0;
    rst_n = 1'b1;
    #1;
    reset_pulse();

    // Reset state seen through the read port.
    cycle(1'b0, 8'h00, 1'b0, 0);
    check("rst.code",        int'(bus8.code),        7);
    check("rst.rom_overrun", int'(bus8.rom_overrun), 1);
    check("rst.prog_len",    int'(bus8.prog_len),    0);
    check("rst.byte_ready",  int'(bus8.byte_ready),  0);

    // Basic program; the depth-4 instance overflows on the fifth command.
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("+-[>.]!", 0);
    read_addrs(0, 6);
    check("basic.prog_len", int'(bus8.prog_len), 6);
    check("small.load_err", int'(bus2.load_err), 1);
    check("small.prog_len", int'(bus2.prog_len), 4);

    // Filler bytes with valid toggling.
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("a+ b\n-!", 1);
    read_addrs(0, 3);
    check("filler.prog_len", int'(bus8.prog_len), 2);

    // Overflow of the depth-4 instance with a full-length term.
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("+++++!", 0);
    read_addrs(0, 5);
    check("ovf.load_err", int'(bus2.load_err), 1);
    check("ovf.prog_len", int'(bus2.prog_len), 4);

    // Restart mid-load; the byte offered with load_start is discarded.
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("++", 0);
    cycle(1'b1, "+", 1'b1, 0);
    check("restart.busy", int'(bus8.busy), 1);
    send("-!", 0);
    read_addrs(0, 2);
    check("restart.prog_len", int'(bus8.prog_len), 1);

    // Bracket balance cases.
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("]!", 0);
    check("brk.close_first", int'(bus8.bracket_err), BCHK ? 1 : 0);
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("[[]!", 0);
    check("brk.open_left", int'(bus8.bracket_err), BCHK ? 1 : 0);
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("[]!", 0);
    check("brk.balanced", int'(bus8.bracket_err), 0);

    // Depth-256 overflow.
    cycle(1'b1, 8'h00, 1'b0, 0);
    for (int c = 0; c < 258; c++) send_byte(((c % 3) == 0) ? "-" : "+", 0);
    send_byte(TERM, 0);
    read_phase(10);
    read_addrs(250, 257);
    check("big.load_err", int'(bus8.load_err), 1);
    check("big.prog_len", int'(bus8.prog_len), 256);

    // Reset in the middle of a load.
    cycle(1'b1, 8'h00, 1'b0, 0);
    send("+>+", 0);
    reset_pulse();
    read_addrs(0, 3);

    // Random programs with random valid, occasional restarts.
    for (int t = 0; t < 14; t++) begin
      int n = $urandom_range(0, 120);
      cycle(1'b1, 8'h00, 1'b0, 0);
      for (int c = 0; c < n; c++) begin
        int p = $urandom_range(0, pool.len() - 1);
        if ($urandom_range(0, 99) == 0) cycle(1'b1, pool[p], 1'b1, $urandom_range(0, 300));
        send_byte(pool[p], 2);
      end
      send_byte(TERM, 2);
      read_phase(24);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
